ddc_line_filter: RTL

DDC_LINE_FILTER -- requirements
Module: ddc_line_filter

---
 rtl/ddc_line_filter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ddc_line_filter.sv
// ---------------------------------------------------------------------------
// ddc_line_filter
//
// Front end for a DDC/EDID slave. Each raw line (SCL, SDA) is brought into
// the clk domain through a two-flop synchronizer and then debounced. A new
// level is accepted only after FILT_LEN consecutive synchronized samples
// disagree with the current filtered level. Shorter disagreements are
// counted as glitches. START/STOP detection runs on the filtered lines.
//
// Handshake: none. The block is a free-running stream filter. Every output
// is a flop updated on each rising edge of clk. There is no valid/ready
// pairing: pulses are single-cycle strobes and levels are always valid
// outside reset.
//
// Parameters
//   FILT_LEN    consecutive-sample count needed to accept a change (1..15)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   scl_i       raw DDC clock line (asynchronous to clk)
//   sda_i       raw DDC data line (asynchronous to clk)
//   scl_o       filtered SCL level
//   sda_o       filtered SDA level
//   scl_rise    one-cycle pulse, first cycle scl_o shows 1
//   scl_fall    one-cycle pulse, first cycle scl_o shows 0
//   start       one-cycle pulse on START / repeated START
//   stop        one-cycle pulse on STOP
//   bus_busy    high between START and STOP
//   glitch_cnt  saturating count of rejected glitches, both lines
// ---------------------------------------------------------------------------
module ddc_line_filter #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       start,
    output logic       stop,
    output logic       bus_busy,
    output logic [7:0] glitch_cnt
);

    // Run-counter value on which the next differing sample completes the run.
    localparam logic [3:0] RUN_LAST = 4'(FILT_LEN - 1);

    // Bit 0 carries SCL, bit 1 carries SDA throughout.
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      filt_q, filt_d;
    logic [1:0][3:0] run_q, run_d;
    logic [1:0]      glitch_end;

    logic [7:0] glitch_cnt_q, glitch_cnt_d;
    logic [8:0] glitch_sum;

    logic scl_rise_q, scl_rise_d;
    logic scl_fall_q, scl_fall_d;
    logic start_q, start_d;
    logic stop_q, stop_d;
    logic busy_q, busy_d;

    // Per-line debounce: count consecutive disagreeing samples; the sample
    // that would bring the count to FILT_LEN flips the filtered level.
    always_comb begin
        filt_d     = filt_q;
        run_d      = '0;
        glitch_end = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (run_q[i] == RUN_LAST) begin
                    filt_d[i] = ~filt_q[i];
                    run_d[i]  = '0;
                end else begin
                    run_d[i] = run_q[i] + 4'd1;
                end
            end else begin
                // Sample fell back to the filtered level before the run
                // completed: that run was a glitch.
                glitch_end[i] = (run_q[i] != 4'd0);
            end
        end
    end

    // Both lines may end a glitch together, so the step is 0, 1 or 2.
    always_comb begin
        glitch_sum   = 9'(glitch_cnt_q) + 9'(glitch_end[0]) + 9'(glitch_end[1]);
        glitch_cnt_d = (glitch_sum > 9'd255) ? 8'hFF : glitch_sum[7:0];
    end

    // Edge and condition detection on the filtered levels. START/STOP need
    // SCL high and unchanged across the edge where SDA moves, so a
    // simultaneous SCL/SDA toggle yields only the SCL edge pulse.
    always_comb begin
        scl_rise_d = ~filt_q[0] &  filt_d[0];
        scl_fall_d =  filt_q[0] & ~filt_d[0];
        start_d    =  filt_q[0] &  filt_d[0] &  filt_q[1] & ~filt_d[1];
        stop_d     =  filt_q[0] &  filt_d[0] & ~filt_q[1] &  filt_d[1];
        busy_d     = busy_q;
        if (start_d) begin
            busy_d = 1'b1;
        end else if (stop_d) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= 2'b11;
            sync2_q      <= 2'b11;
            filt_q       <= 2'b11;
            run_q        <= '0;
            glitch_cnt_q <= 8'd0;
            scl_rise_q   <= 1'b0;
            scl_fall_q   <= 1'b0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= {sda_i, scl_i};
            sync2_q      <= sync1_q;
            filt_q       <= filt_d;
            run_q        <= run_d;
            glitch_cnt_q <= glitch_cnt_d;
            scl_rise_q   <= scl_rise_d;
            scl_fall_q   <= scl_fall_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            busy_q       <= busy_d;
        end
    end

    assign scl_o      = filt_q[0];
    assign sda_o      = filt_q[1];
    assign scl_rise   = scl_rise_q;
    assign scl_fall   = scl_fall_q;
    assign start      = start_q;
    assign stop       = stop_q;
    assign bus_busy   = busy_q;
    assign glitch_cnt = glitch_cnt_q;

endmodule
